ccff_bitstream_loader: RTL and testbench
========================================

# ccff_bitstream_loader

Serial configuration-chain writer for the fabric's configuration flip-flop chain. Accepts bitstream words from the SoC-side loader over a valid/ready handshake and shifts them, one bit per `prog_clk`, into the chain's `ccff_head`. While shifting it drives the chain's `config_enable`, and it counts bits so that exactly `CHAIN_LEN` bits are delivered. Sits at the head of each configuration chain, opposite the last tile's `ccff_tail`.

## Interface
- `CHAIN_LEN`, default 1024: total configuration bits in the chain; must be ≥1.
- `WORD_W`, default 32: bitstream word width; must be ≥2.
- `prog_clk` input 1: programming clock; all logic is on its rising edge.
- `pReset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a load; honoured only in IDLE.
- `abort` input 1: synchronous cancel of a load in progress.
- `word_data` input WORD_W: bitstream word; bit 0 is shifted first.
- `word_valid` input 1: `word_data` is valid.
- `word_ready` output 1: the loader accepts the word this cycle.
- `ccff_head` output 1: serial data into the chain.
- `ccff_tail` input 1: serial data returning from the chain end.
- `config_enable` output 1: the chain advances by one bit on every cycle in which this is high.
- `busy` output 1: a load is in progress.
- `done` output 1: one-cycle pulse after the last bit has been shifted.
- `aborted` output 1: one-cycle pulse when a load is cancelled.
- `tail_crc` output 16: CRC over the `ccff_tail` stream (see Configuration).

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - `start=1` → FETCH.
  - `bits_left` ← CHAIN_LEN; `tail_crc` ← 0xFFFF.
- FETCH:
  - `word_ready=1`.
  - On `word_valid&&word_ready`, the word is latched into the shift register, `bit_idx` ← 0, next state SHIFT.
- SHIFT:
  - `config_enable=1`; `ccff_head` = `shreg[0]`.
  - Each cycle: shreg shifts right, `bit_idx++`, `bits_left--`.
  - If `bits_left==1` this cycle → DONE. The rest of the current word is discarded.
  - Otherwise, if `bit_idx==WORD_W-1` → FETCH.
- DONE: `done=1` for one cycle → IDLE.
- `abort` in FETCH or SHIFT:
  - Next state is IDLE and `aborted=1` for one cycle. `done` is not asserted.
  - A word offered in that same cycle is not accepted.
  - `abort` in IDLE or DONE has no effect.
- `busy=1` in FETCH, SHIFT and DONE.
- `start` while not IDLE is ignored.
- `abort` and `start` together in IDLE: `start` wins.
- `pReset` overrides everything; next state is IDLE.
- Counter widths:
  - `bits_left` is `$clog2(CHAIN_LEN+1)` bits.
  - `bit_idx` is `$clog2(WORD_W)` bits.
  - Neither counter ever wraps.

## Timing
- Reset values of outputs: `word_ready=0`, `ccff_head=0`, `config_enable=0`, `busy=0`, `done=0`, `aborted=0`, `tail_crc=0xFFFF`.
- Outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs except `word_ready` (state only).
- Handshake cycle N (FETCH) → first bit of that word on `ccff_head` with `config_enable=1` in cycle N+1.
- Each full word costs WORD_W+1 cycles: one FETCH cycle plus WORD_W SHIFT cycles.
- Producer stall: FETCH holds with `config_enable=0`, so the chain holds its contents.
- `done` asserts in the cycle after the final SHIFT cycle.
- Total `config_enable`-high cycles per completed load = CHAIN_LEN exactly.
- `abort` sampled in cycle N: `config_enable=0` from cycle N+1.

## Configuration
- Macro: `CCFF_LOADER_TAIL_CRC_EN`.
- Defined:
  - `tail_crc` is CRC-16-CCITT (polynomial 0x1021, MSB-first serial form, init 0xFFFF).
  - It is updated on each SHIFT cycle with `ccff_tail` sampled that cycle.
  - It is preset to 0xFFFF on `start` and holds its value after DONE or abort. This exposes the previous chain contents for readback verification.
- Undefined: `tail_crc` is tied to 0x0000, `ccff_tail` is unused, and no CRC logic is present.

## Test plan
- CHAIN_LEN=40, WORD_W=32, words 0xA5A5A5A5 and 0x000000C3, `word_valid` always high:
  - Exactly 40 `config_enable` cycles.
  - Chain model holds bits 0xA5A5A5A5 then 0xC3 in shift order.
  - `done` pulses once; the second `word_ready` appears 33 cycles after the first.
- Same load with `word_valid` low for 5 cycles before the second word: `config_enable` is low for 6 cycles between the words, the chain contents are unchanged, and the final result is identical.
- `abort` asserted on the 10th SHIFT cycle:
  - `config_enable=0` from the next cycle.
  - `aborted` pulses once and `done` never pulses.
  - `busy=0` two cycles after `abort`.
- `pReset` mid-SHIFT: in the next cycle all outputs are at their reset values; the next `start` restarts with a full CHAIN_LEN count.
- `start` pulsed during SHIFT is ignored, with no count change; `start` and `abort` together in IDLE begin a load.
- With `CCFF_LOADER_TAIL_CRC_EN`, chain model preloaded with 40 ones: `tail_crc` equals the bench's CRC-16-CCITT model over 40 one-bits. Without the macro, `tail_crc` stays 0x0000.

Source files
------------

// File: rtl/ccff_bitstream_loader_if.sv
// Word handshake between the SoC-side bitstream producer and the chain loader.
interface ccff_bitstream_loader_if #(
   parameter int WORD_W = 32
);
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;

   modport master (output word_data, output word_valid, input word_ready);
   modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serial writer for a configuration flip-flop chain: words in, one bit per prog_clk out.
// Optional tail readback CRC enabled by defining CCFF_LOADER_TAIL_CRC_EN.
module ccff_bitstream_loader #(
   parameter int CHAIN_LEN = 1024,
   parameter int WORD_W    = 32
) (
   input  logic                    prog_clk,
   input  logic                    pReset,
   input  logic                    start,
   input  logic                    abort,
   ccff_bitstream_loader_if.slave  word_bus,
   output logic                    ccff_head,
   input  logic                    ccff_tail,
   output logic                    config_enable,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic [15:0]             tail_crc
);
   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int IDX_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SHIFT, ST_DONE} state_t;

   state_t            state, state_nxt;
   logic [WORD_W-1:0] shreg;
   logic [IDX_W-1:0]  bit_idx;
   logic [CNT_W-1:0]  bits_left;
   logic              abort_take;
   logic              word_take;

   always_ff @(posedge prog_clk) begin
      if (pReset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      abort_take = 1'b0;
      word_take  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (abort) begin
               state_nxt  = ST_IDLE;
               abort_take = 1'b1;
            end else if (word_bus.word_valid) begin
               state_nxt = ST_SHIFT;
               word_take = 1'b1;
            end
         end
         ST_SHIFT: begin
            // Chain end reached mid-word: the unsent tail of the word is dropped.
            if (abort) begin
               state_nxt  = ST_IDLE;
               abort_take = 1'b1;
            end else if (bits_left == CNT_W'(1)) begin
               state_nxt = ST_DONE;
            end else if (bit_idx == IDX_LAST) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs are pure state decodes, so no input reaches an output combinationally.
   assign word_bus.word_ready = (state == ST_FETCH);
   assign config_enable       = (state == ST_SHIFT);
   assign ccff_head           = config_enable & shreg[0];
   assign busy                = (state != ST_IDLE);
   assign done                = (state == ST_DONE);

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         shreg     <= '0;
         bit_idx   <= '0;
         bits_left <= CNT_FULL;
         aborted   <= 1'b0;
      end else begin
         aborted <= abort_take;
         case (state)
            ST_IDLE: bits_left <= CNT_FULL;
            ST_FETCH: begin
               if (word_take) begin
                  shreg   <= word_bus.word_data;
                  bit_idx <= '0;
               end
            end
            ST_SHIFT: begin
               shreg <= shreg >> 1;
               if (bit_idx != IDX_LAST)      bit_idx   <= bit_idx + IDX_W'(1);
               if (bits_left != CNT_W'(0))   bits_left <= bits_left - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef CCFF_LOADER_TAIL_CRC_EN
   // CRC-16-CCITT, MSB-first, over the bits leaving the chain while it shifts.
   logic [15:0] crc_q;
   logic        crc_fb;

   assign crc_fb = crc_q[15] ^ ccff_tail;

   always_ff @(posedge prog_clk) begin
      if (pReset)
         crc_q <= 16'hFFFF;
      else if (state == ST_IDLE && start)
         crc_q <= 16'hFFFF;
      else if (state == ST_SHIFT)
         crc_q <= {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
   end

   assign tail_crc = crc_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
   assign tail_crc    = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: loads push expected end-of-load records, a monitor checks each done/aborted pulse.
module tb_ccff_bitstream_loader;
   localparam int CL = 40;
   localparam int WW = 32;
   localparam logic [39:0] EXP_CHAIN = 40'hC3_A5A5A5A5;
`ifdef CCFF_LOADER_TAIL_CRC_EN
   localparam logic [15:0] CRC_RST = 16'hFFFF;
`else
   localparam logic [15:0] CRC_RST = 16'h0000;
`endif

   logic        prog_clk = 1'b0;
   logic        pReset   = 1'b1;
   logic        start    = 1'b0;
   logic        abort    = 1'b0;
   logic        ccff_head, ccff_tail, config_enable, busy, done, aborted;
   logic [15:0] tail_crc;
   logic        preload  = 1'b0;

   ccff_bitstream_loader_if #(.WORD_W(WW)) wb ();

   ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clk     (prog_clk),
      .pReset       (pReset),
      .start        (start),
      .abort        (abort),
      .word_bus     (wb.slave),
      .ccff_head    (ccff_head),
      .ccff_tail    (ccff_tail),
      .config_enable(config_enable),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .tail_crc     (tail_crc)
   );

   always #5 prog_clk = ~prog_clk;

   typedef struct {
      bit          is_abort;
      int          ce;
      bit          chk_chain;
      logic [39:0] chain;
      bit          chk_crc;
      logic [15:0] crc;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;

   // Chain model: index 0 is the far end feeding ccff_tail.
   logic [39:0] chain_m  = '0;
   int          ce_total = 0;
   int          ce_mark  = 0;

   assign ccff_tail = chain_m[0];

   always @(posedge prog_clk) begin
      if (preload)            chain_m <= '1;
      else if (config_enable) chain_m <= {ccff_head, chain_m[39:1]};
      if (config_enable)      ce_total <= ce_total + 1;
      if (start && !busy)     ce_mark  <= ce_total;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_ones(input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         fb = c[15] ^ 1'b1;
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   always @(negedge prog_clk) begin
      exp_t e;
      if (!pReset && (done || aborted)) begin
         if (sb.size() == 0) begin
            chk("unexpected_event", {62'd0, done, aborted}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("event_kind_aborted", 64'(aborted), 64'(e.is_abort));
            chk("event_kind_done", 64'(done), 64'(!e.is_abort));
            chk("ce_cycles", 64'(ce_total - ce_mark), 64'(e.ce));
            if (e.chk_chain) chk("chain_contents", 64'(chain_m), 64'(e.chain));
            if (e.chk_crc)   chk("tail_crc", 64'(tail_crc), 64'(e.crc));
         end
      end
   end

   task automatic push_exp(input bit is_abort, input int ce, input bit chk_chain,
                           input bit chk_crc, input logic [15:0] crc);
      exp_t e;
      e.is_abort  = is_abort;
      e.ce        = ce;
      e.chk_chain = chk_chain;
      e.chain     = EXP_CHAIN;
      e.chk_crc   = chk_crc;
      e.crc       = crc;
      sb.push_back(e);
   endtask

   task automatic run_load(input int stall, input int abort_at, input bit start_mid,
                           input bit abort_with_start, input int reset_at);
      logic [31:0] w[2];
      int widx = 0, stall_left = stall, shifts = 0, cyc = 0;
      int rdy0 = -1, rdy1 = -1, ce_snap = 0;
      bit fin = 0, ab_pend = 0;
      w[0] = 32'hA5A5A5A5;
      w[1] = 32'h000000C3;
      @(negedge prog_clk);
      start = 1'b1;
      abort = abort_with_start;
      @(negedge prog_clk);
      start = 1'b0;
      abort = 1'b0;
      while (!fin && cyc < 400) begin
         wb.word_valid = 1'b0;
         if (done || aborted) begin
            fin = 1;
         end else begin
            if (wb.word_ready && widx < 2) begin
               if (widx == 0 && rdy0 < 0) rdy0 = cyc;
               if (widx == 1 && rdy1 < 0) rdy1 = cyc;
               if (widx == 1 && stall_left > 0) begin
                  if (stall_left == stall) ce_snap = ce_total;
                  stall_left--;
                  chk("stall_ce_low", 64'(config_enable), 64'd0);
                  if (stall_left == 0) begin
                     chk("stall_chain_hold", 64'(chain_m[39:8]), 64'hA5A5A5A5);
                     chk("stall_no_shift", 64'(ce_total - ce_snap), 64'd0);
                  end
               end else begin
                  wb.word_valid = 1'b1;
                  wb.word_data  = w[widx];
                  widx++;
               end
            end
            if (config_enable) begin
               shifts++;
               if (shifts == abort_at) begin
                  abort   = 1'b1;
                  ab_pend = 1;
               end
               if (start_mid && shifts == 5) start = 1'b1;
               if (shifts == reset_at) pReset = 1'b1;
            end
         end
         @(negedge prog_clk);
         cyc++;
         start = 1'b0;
         abort = 1'b0;
         if (pReset) begin
            chk("rst_word_ready", 64'(wb.word_ready), 64'd0);
            chk("rst_ccff_head", 64'(ccff_head), 64'd0);
            chk("rst_config_enable", 64'(config_enable), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_aborted", 64'(aborted), 64'd0);
            chk("rst_tail_crc", 64'(tail_crc), 64'(CRC_RST));
            pReset = 1'b0;
            wb.word_valid = 1'b0;
            return;
         end
         if (ab_pend) begin
            chk("abort_ce_off", 64'(config_enable), 64'd0);
            ab_pend = 0;
         end
      end
      wb.word_valid = 1'b0;
      if (!fin) chk("load_timeout", 64'(cyc), 64'd0);
      if (abort_at > 0) begin
         @(negedge prog_clk);
         chk("abort_busy_low", 64'(busy), 64'd0);
      end else begin
         chk("ready_gap", 64'(rdy1 - rdy0), 64'd33);
      end
   endtask

   initial begin
      wb.word_valid = 1'b0;
      wb.word_data  = '0;
      repeat (3) @(negedge prog_clk);
      chk("reset_word_ready", 64'(wb.word_ready), 64'd0);
      chk("reset_ce", 64'(config_enable), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_tail_crc", 64'(tail_crc), 64'(CRC_RST));
      pReset = 1'b0;

      // Straight load, producer always ready.
      push_exp(0, CL, 1, 0, 16'h0);
      run_load(0, 0, 0, 0, 0);
      // Producer stalls 5 cycles before the second word.
      push_exp(0, CL, 1, 0, 16'h0);
      run_load(5, 0, 0, 0, 0);
      // Abort on the 10th shift cycle.
      push_exp(1, 10, 0, 0, 16'h0);
      run_load(0, 10, 0, 0, 0);
      // Reset mid-shift, then a full reload.
      run_load(0, 0, 0, 0, 7);
      push_exp(0, CL, 1, 0, 16'h0);
      run_load(0, 0, 0, 0, 0);
      // start during SHIFT ignored; start+abort in IDLE begins a load.
      push_exp(0, CL, 1, 0, 16'h0);
      run_load(0, 0, 1, 0, 0);
      push_exp(0, CL, 1, 0, 16'h0);
      run_load(0, 0, 0, 1, 0);
      // Readback CRC over a chain preloaded with ones.
      @(negedge prog_clk);
      preload = 1'b1;
      @(negedge prog_clk);
      preload = 1'b0;
`ifdef CCFF_LOADER_TAIL_CRC_EN
      push_exp(0, CL, 1, 1, crc_ones(CL));
`else
      push_exp(0, CL, 1, 1, 16'h0000);
`endif
      run_load(0, 0, 0, 0, 0);

      repeat (5) @(negedge prog_clk);
      chk("pending_events", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
